// File: rtl/display_scheduler.sv
// Rotating content scheduler for the SHD0028 6-digit display driver: captures
// thermometer, hygrometer and RTC samples and sequences them onto the driver inputs.
module display_scheduler #(
  parameter int unsigned TICK_DIV   = 25_000_000,
  parameter int unsigned DWELL_TIME = 10,
  parameter int unsigned DWELL_TEMP = 10,
  parameter int unsigned DWELL_HUM  = 6
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic [12:0] TEMP_BCD,
  input  logic        TEMP_VALID,
  input  logic [11:0] HUM_BCD,
  input  logic        HUM_VALID,
  input  logic [23:0] RTC_BCD,
  input  logic        RTC_VALID,
  input  logic        NEXT,
  output logic [23:0] DISP_DATA,
  output logic        DISP_SEL,
  output logic        DISP_COLON,
  output logic [1:0]  MODE
);

  localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DWELL_W = 4;
  localparam int unsigned DATA_W  = 24;
  localparam int unsigned TEMP_W  = 13;
  localparam int unsigned HUM_W   = 12;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TIME = 2'd1,
    ST_TEMP = 2'd2,
    ST_HUM  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0]  dwell_last_c;
  logic                colon_q, colon_d;
  logic                tick_c;
  logic                advance_c;

  logic [DATA_W-1:0]   rtc_q, rtc_d;
  logic [TEMP_W-1:0]   temp_q, temp_d;
  logic [HUM_W-1:0]    hum_q, hum_d;
  logic                have_rtc_q, have_rtc_d;
  logic                have_temp_q, have_temp_d;
  logic                have_hum_q, have_hum_d;

  logic [DATA_W-1:0]   disp_data_q, disp_data_d;
  logic                disp_sel_q, disp_sel_d;
  logic                disp_colon_q, disp_colon_d;
  logic [1:0]          mode_q, mode_d;

  // First source after cur in TIME -> TEMP -> HUM order that has a sample; from IDLE, first valid one.
  function automatic state_e next_source(input state_e cur, input logic hr,
                                         input logic ht, input logic hh);
    state_e nxt;
    case (cur)
      ST_TIME: nxt = ht ? ST_TEMP : (hh ? ST_HUM  : ST_TIME);
      ST_TEMP: nxt = hh ? ST_HUM  : (hr ? ST_TIME : ST_TEMP);
      ST_HUM:  nxt = hr ? ST_TIME : (ht ? ST_TEMP : ST_HUM);
      default: nxt = hr ? ST_TIME : (ht ? ST_TEMP : (hh ? ST_HUM : ST_IDLE));
    endcase
    return nxt;
  endfunction

  assign tick_c = (tick_cnt_q == TICK_LAST);

  // Shadow capture, sticky presence flags and free-running half-second divider.
  always_comb begin
    rtc_d       = rtc_q;
    temp_d      = temp_q;
    hum_d       = hum_q;
    have_rtc_d  = have_rtc_q;
    have_temp_d = have_temp_q;
    have_hum_d  = have_hum_q;
    tick_cnt_d  = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
    if (RTC_VALID) begin
      rtc_d      = RTC_BCD;
      have_rtc_d = 1'b1;
    end
    if (TEMP_VALID) begin
      temp_d      = TEMP_BCD;
      have_temp_d = 1'b1;
    end
    if (HUM_VALID) begin
      hum_d      = HUM_BCD;
      have_hum_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      rtc_q       <= '0;
      temp_q      <= '0;
      hum_q       <= '0;
      have_rtc_q  <= 1'b0;
      have_temp_q <= 1'b0;
      have_hum_q  <= 1'b0;
      tick_cnt_q  <= '0;
    end else begin
      rtc_q       <= rtc_d;
      temp_q      <= temp_d;
      hum_q       <= hum_d;
      have_rtc_q  <= have_rtc_d;
      have_temp_q <= have_temp_d;
      have_hum_q  <= have_hum_d;
      tick_cnt_q  <= tick_cnt_d;
    end
  end

  always_comb begin
    dwell_last_c = '0;
    case (state_q)
      ST_TIME: dwell_last_c = DWELL_W'(DWELL_TIME - 1);
      ST_TEMP: dwell_last_c = DWELL_W'(DWELL_TEMP - 1);
      ST_HUM:  dwell_last_c = DWELL_W'(DWELL_HUM - 1);
      default: dwell_last_c = '0;
    endcase
  end

  // FSM state register, including the dwell counter and colon phase.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q     <= ST_IDLE;
      dwell_cnt_q <= '0;
      colon_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_cnt_q <= dwell_cnt_d;
      colon_q     <= colon_d;
    end
  end

  // Next state: NEXT and dwell expiry share one advance, so a coincidence steps once.
  always_comb begin
    state_d     = state_q;
    dwell_cnt_d = dwell_cnt_q;
    colon_d     = colon_q;
    advance_c   = 1'b0;
    if (state_q == ST_IDLE) begin
      advance_c = have_rtc_q | have_temp_q | have_hum_q;
    end else begin
      advance_c = NEXT | (tick_c && (dwell_cnt_q == dwell_last_c));
    end
    if (advance_c) begin
      state_d     = next_source(state_q, have_rtc_q, have_temp_q, have_hum_q);
      dwell_cnt_d = '0;
      colon_d     = (state_d == ST_TIME);
    end else if (tick_c && (state_q != ST_IDLE)) begin
      dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
      colon_d     = (state_q == ST_TIME) ? ~colon_q : 1'b0;
    end
  end

  // Output frame, formatted from the state and live shadow contents.
  always_comb begin
    disp_data_d  = '0;
    disp_sel_d   = 1'b0;
    disp_colon_d = 1'b0;
    mode_d       = state_q;
    case (state_q)
      ST_TIME: begin
        disp_data_d  = rtc_q;
        disp_colon_d = colon_q;
      end
      ST_TEMP: begin
        disp_data_d = {10'b0, temp_q[12], 1'b1, temp_q[11:0]};
        disp_sel_d  = 1'b1;
      end
      ST_HUM: begin
        disp_data_d = {10'b0, 1'b0, 1'b0, hum_q};
        disp_sel_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // All display outputs share one register stage so the driver never sees a mixed frame.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      disp_data_q  <= '0;
      disp_sel_q   <= 1'b0;
      disp_colon_q <= 1'b0;
      mode_q       <= '0;
    end else begin
      disp_data_q  <= disp_data_d;
      disp_sel_q   <= disp_sel_d;
      disp_colon_q <= disp_colon_d;
      mode_q       <= mode_d;
    end
  end

  assign DISP_DATA  = disp_data_q;
  assign DISP_SEL   = disp_sel_q;
  assign DISP_COLON = disp_colon_q;
  assign MODE       = mode_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler: a cycle-level behavioural model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_display_scheduler;

  localparam int unsigned TD      = 4;
  localparam int unsigned DW_TIME = 3;
  localparam int unsigned DW_TEMP = 2;
  localparam int unsigned DW_HUM  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] temp_bcd;
  logic        temp_valid;
  logic [11:0] hum_bcd;
  logic        hum_valid;
  logic [23:0] rtc_bcd;
  logic        rtc_valid;
  logic        next_p;
  logic [23:0] disp_data;
  logic        disp_sel;
  logic        disp_colon;
  logic [1:0]  mode;

  int checks = 0;
  int errors = 0;

  display_scheduler #(
    .TICK_DIV  (TD),
    .DWELL_TIME(DW_TIME),
    .DWELL_TEMP(DW_TEMP),
    .DWELL_HUM (DW_HUM)
  ) dut (
    .CLK       (clk),
    .RST_n     (rst_n),
    .TEMP_BCD  (temp_bcd),
    .TEMP_VALID(temp_valid),
    .HUM_BCD   (hum_bcd),
    .HUM_VALID (hum_valid),
    .RTC_BCD   (rtc_bcd),
    .RTC_VALID (rtc_valid),
    .NEXT      (next_p),
    .DISP_DATA (disp_data),
    .DISP_SEL  (disp_sel),
    .DISP_COLON(disp_colon),
    .MODE      (mode)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_state;          // 0 idle, 1 time, 2 temp, 3 hum
  int unsigned m_cyc;            // cycles since reset release
  int unsigned m_ticks;          // ticks seen in the current visit
  logic [23:0] m_rtc;
  logic [12:0] m_temp;
  logic [11:0] m_hum;
  bit          m_have[4];
  int          order[3]    = '{1, 2, 3};
  int unsigned dwell_of[4] = '{0, DW_TIME, DW_TEMP, DW_HUM};
  logic [23:0] e_data;
  logic        e_sel;
  logic        e_colon;
  logic [1:0]  e_mode;
  bit          started = 1'b0;

  function automatic int pick_next(input int cur);
    int start;
    int c;
    start = (cur == 0) ? 2 : cur - 1;
    for (int k = 1; k <= 3; k++) begin
      c = order[(start + k) % 3];
      if (m_have[c]) return c;
    end
    return cur;
  endfunction

  always @(posedge clk) begin : model
    bit tick;
    if (!rst_n) begin
      m_state = 0;
      m_cyc   = 0;
      m_ticks = 0;
      m_rtc   = '0;
      m_temp  = '0;
      m_hum   = '0;
      for (int i = 0; i < 4; i++) m_have[i] = 1'b0;
      e_data  = '0;
      e_sel   = 1'b0;
      e_colon = 1'b0;
      e_mode  = '0;
    end else begin
      e_mode = 2'(m_state);
      case (m_state)
        1:       e_data = m_rtc;
        2:       e_data = 24'h001000 + (m_temp[12] ? 24'h002000 : 24'h0) + 24'(m_temp[11:0]);
        3:       e_data = 24'(m_hum);
        default: e_data = 24'h0;
      endcase
      e_sel   = (m_state >= 2);
      e_colon = (m_state == 1) && (m_ticks % 2 == 0);
      tick = (m_cyc % TD) == TD - 1;
      if (m_state == 0) begin
        m_state = pick_next(0);
        m_ticks = 0;
      end else if (next_p || (tick && (m_ticks + 1 == dwell_of[m_state]))) begin
        m_state = pick_next(m_state);
        m_ticks = 0;
      end else if (tick) begin
        m_ticks++;
      end
      m_cyc++;
      if (rtc_valid)  begin m_rtc  = rtc_bcd;  m_have[1] = 1'b1; end
      if (temp_valid) begin m_temp = temp_bcd; m_have[2] = 1'b1; end
      if (hum_valid)  begin m_hum  = hum_bcd;  m_have[3] = 1'b1; end
    end
    started = 1'b1;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    checks++;
    if (val < lo || val > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, val, lo, hi, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("model_mode",  24'(mode),       24'(e_mode));
      check("model_data",  disp_data,       e_data);
      check("model_sel",   24'(disp_sel),   24'(e_sel));
      check("model_colon", 24'(disp_colon), 24'(e_colon));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_mode(input logic [1:0] m, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (mode !== m && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_mode", 24'(mode), 24'(m));
  endtask

  task automatic measure(input logic [1:0] m, output int len);
    len = 0;
    while (mode === m && len < 200) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic lit_frame(input string name, input logic [1:0] m, input logic [23:0] d,
                           input logic s, input logic c);
    check({name, "_mode"},  24'(mode),       24'(m));
    check({name, "_data"},  disp_data,       d);
    check({name, "_sel"},   24'(disp_sel),   24'(s));
    check({name, "_colon"}, 24'(disp_colon), 24'(c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int cnt_a;
    int cnt_b;
    int lh;
    int lt;
    int lp;
    rst_n = 1'b0;
    temp_bcd = '0; temp_valid = 1'b0;
    hum_bcd = '0;  hum_valid = 1'b0;
    rtc_bcd = '0;  rtc_valid = 1'b0;
    next_p = 1'b0;
    cyc(3);
    rst_n = 1'b1;

    // 1: reset and idle
    cyc(100);
    @(negedge clk);
    lit_frame("idle", 2'd0, 24'h0, 1'b0, 1'b0);

    // 2: RTC only, three-cycle latency, stays in TIME
    cyc(1);
    rtc_bcd = 24'h123456; rtc_valid = 1'b1;
    cyc(1);
    rtc_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rtc_lat2_mode", 24'(mode), 24'd0);
    @(negedge clk);
    lit_frame("rtc_first", 2'd1, 24'h123456, 1'b0, 1'b1);
    cnt_a = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mode !== 2'd1) cnt_a++;
    end
    check_range("rtc_stays_time", cnt_a, 0, 0);

    // 3/4: load TEMP and HUM, NEXT mid-dwell
    cyc(1);
    temp_bcd = 13'h1234; temp_valid = 1'b1;
    hum_bcd = 12'h456;   hum_valid = 1'b1;
    cyc(1);
    temp_valid = 1'b0; hum_valid = 1'b0;
    cyc(2);
    n = 0;
    while (!(m_state == 1 && m_ticks + 1 < DW_TIME) && n < 100) begin
      cyc(1);
      n++;
    end
    check_range("mid_dwell_wait", n, 0, 99);
    next_p = 1'b1;
    cyc(1);
    next_p = 1'b0;
    @(posedge clk);
    @(negedge clk);
    lit_frame("next_mid", 2'd2, 24'h003234, 1'b1, 1'b0);

    // NEXT coincident with dwell expiry: single step to TEMP
    wait_mode(2'd1, 100);
    cyc(1);
    n = 0;
    while (!(m_state == 1 && m_ticks + 1 == DW_TIME && (m_cyc % TD) == TD - 1) && n < 100) begin
      cyc(1);
      n++;
    end
    check_range("coincide_wait", n, 0, 99);
    next_p = 1'b1;
    cyc(1);
    next_p = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("coincide_mode", 24'(mode), 24'd2);
    repeat (4) @(negedge clk);
    check("coincide_single_step", 24'(mode), 24'd2);

    // full rotation with dwell lengths
    wait_mode(2'd3, 40);
    check("hum_data", disp_data, 24'h000456);
    measure(2'd3, lh);
    check("rot_after_hum", 24'(mode), 24'd1);
    measure(2'd1, lt);
    check("rot_after_time", 24'(mode), 24'd2);
    measure(2'd2, lp);
    check("rot_after_temp", 24'(mode), 24'd3);
    check_range("hum_len",  lh, 7, 9);
    check_range("time_len", lt, 11, 13);
    check_range("temp_len", lp, 7, 9);

    // 6: live update while HUM is shown
    cyc(1);
    hum_bcd = 12'h789; hum_valid = 1'b1;
    cyc(1);
    hum_valid = 1'b0;
    @(negedge clk);
    check("live_before", disp_data, 24'h000456);
    @(negedge clk);
    lit_frame("live_after", 2'd3, 24'h000789, 1'b1, 1'b0);

    // reset mid-operation
    cyc(1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    @(negedge clk);
    lit_frame("mid_reset", 2'd0, 24'h0, 1'b0, 1'b0);
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mode !== 2'd0) cnt_a++;
    end
    check_range("post_reset_idle", cnt_a, 0, 0);

    // 5: only RTC and HUM: TEMP never entered
    cyc(1);
    rtc_bcd = 24'h081500; rtc_valid = 1'b1;
    hum_bcd = 12'h600;    hum_valid = 1'b1;
    cyc(1);
    rtc_valid = 1'b0; hum_valid = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (mode === 2'd2) cnt_a++;
      if (mode === 2'd3) cnt_b++;
    end
    check_range("skip_temp_cycles", cnt_a, 0, 0);
    check_range("skip_hum_cycles", cnt_b, 1, 80);
    wait_mode(2'd3, 40);
    check("skip_hum_data", disp_data, 24'h000600);

    // reset, then a positive temperature arriving alone
    cyc(1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    temp_bcd = 13'h0215; temp_valid = 1'b1;
    cyc(1);
    temp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("temp_lat2_mode", 24'(mode), 24'd0);
    @(negedge clk);
    lit_frame("temp_first", 2'd2, 24'h001215, 1'b1, 1'b0);

    cyc(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
